// File: rtl/b16_uart_debug_if.sv
`default_nettype none
// ============================================================================
// b16_uart_debug_if : debug strobe/data bus between host bridge and b16 cpu
// Rev 1.0
// ============================================================================
interface b16_uart_debug_if;
  logic        dr;
  logic        dw;
  logic [2:0]  daddr;
  logic [15:0] dwdata;
  logic [15:0] drdata;

  modport master (output dr, dw, daddr, dwdata, input drdata);
  modport slave  (input dr, dw, daddr, dwdata, output drdata);
endinterface
`default_nettype wire

// File: rtl/b16_uart_debug.sv
`default_nettype none
// ============================================================================
// b16_uart_debug : UART (8N1) command bridge driving the b16 cpu debug port
// Rev 1.0
// ============================================================================
module b16_uart_debug #(
  parameter logic [15:0] DIV     = 16'd434,
  parameter logic [7:0]  TIMEOUT = 8'd32
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             rxd,
  output logic             txd,
  output logic             drun,
  input  logic             bp_hit,
  b16_uart_debug_if.master dbg
);

  localparam logic [15:0] BIT_LAST  = DIV - 16'd1;
  localparam logic [15:0] HALF_LAST = (DIV >> 1) - 16'd1;
  localparam logic [23:0] TMO_LAST  = 24'(DIV) * 24'(TIMEOUT) - 24'd1;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;
  localparam logic [7:0]  BRK = 8'h42;

  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [2:0] {P_IDLE, P_WHI, P_WLO, P_STROBE, P_RESP} p_st_t;

  // receiver
  logic        sync1_q, sync2_q, prev_q;
  rx_st_t      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        rx_valid, rx_ferr;

  // parser
  p_st_t       p_st_q, p_st_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] dwdata_q, dwdata_d;
  logic        is_wr_q, is_wr_d;
  logic        drun_q, drun_d;
  logic [23:0] tmo_q, tmo_d;
  logic [1:0]  resp_n_q, resp_n_d;
  logic [7:0]  resp0_q, resp0_d, resp1_q, resp1_d;
  logic        dr_c, dw_c;

  // tx queue and transmitter
  logic [7:0]  q0_q, q0_d, q1_q, q1_d;
  logic [1:0]  qcnt_q, qcnt_d;
  logic        bp_pend_q, bp_pend_d;
  logic [1:0]  resp_taken;
  logic        tx_pop;
  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_sh_q, tx_sh_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic        txd_q, txd_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      rx_st_q   <= RX_HUNT;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      p_st_q    <= P_IDLE;
      addr_q    <= '0;
      dwdata_q  <= '0;
      is_wr_q   <= 1'b0;
      drun_q    <= 1'b1;
      tmo_q     <= '0;
      resp_n_q  <= '0;
      resp0_q   <= '0;
      resp1_q   <= '0;
      q0_q      <= '0;
      q1_q      <= '0;
      qcnt_q    <= '0;
      bp_pend_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '1;
      tx_bit_q  <= '0;
      tx_cnt_q  <= '0;
      txd_q     <= 1'b1;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      p_st_q    <= p_st_d;
      addr_q    <= addr_d;
      dwdata_q  <= dwdata_d;
      is_wr_q   <= is_wr_d;
      drun_q    <= drun_d;
      tmo_q     <= tmo_d;
      resp_n_q  <= resp_n_d;
      resp0_q   <= resp0_d;
      resp1_q   <= resp1_d;
      q0_q      <= q0_d;
      q1_q      <= q1_d;
      qcnt_q    <= qcnt_d;
      bp_pend_q <= bp_pend_d;
      tx_busy_q <= tx_busy_d;
      tx_sh_q   <= tx_sh_d;
      tx_bit_q  <= tx_bit_d;
      tx_cnt_q  <= tx_cnt_d;
      txd_q     <= txd_d;
    end
  end

  // Receiver: start bit re-checked half a bit after the falling edge
  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (rx_st_q)
      RX_HUNT: begin
        if (prev_q && !sync2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = HALF_LAST;
        end
      end
      RX_START: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (sync2_q) begin
          rx_st_d = RX_HUNT;
        end else begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = BIT_LAST;
          rx_bit_d = 3'd0;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
          rx_cnt_d = BIT_LAST;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) begin
            rx_st_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else begin
          rx_st_d  = RX_HUNT;
          rx_valid = sync2_q;
          rx_ferr  = !sync2_q;
        end
      end
      default: rx_st_d = RX_HUNT;
    endcase
  end

  // Command parser; responses go to a small holding buffer drained into the queue
  always_comb begin
    p_st_d   = p_st_q;
    addr_d   = addr_q;
    dwdata_d = dwdata_q;
    is_wr_d  = is_wr_q;
    drun_d   = drun_q;
    tmo_d    = '0;
    resp0_d  = resp0_q;
    resp1_d  = resp1_q;
    resp_n_d = resp_n_q;
    dr_c     = 1'b0;
    dw_c     = 1'b0;
    if (resp_taken == 2'd1) begin
      resp0_d  = resp1_q;
      resp_n_d = resp_n_q - 2'd1;
    end else if (resp_taken == 2'd2) begin
      resp_n_d = 2'd0;
    end
    case (p_st_q)
      P_IDLE: begin
        if (rx_valid) begin
          case (rx_sh_q[7:4])
            4'h1, 4'h2: begin
              if (drun_q) begin
                resp0_d  = NAK;
                resp_n_d = 2'd1;
              end else begin
                addr_d  = rx_sh_q[2:0];
                is_wr_d = (rx_sh_q[7:4] == 4'h1);
                p_st_d  = (rx_sh_q[7:4] == 4'h1) ? P_WHI : P_STROBE;
              end
            end
            4'h3: begin
              drun_d   = 1'b1;
              resp0_d  = ACK;
              resp_n_d = 2'd1;
              p_st_d   = P_RESP;
            end
            4'h4: begin
              drun_d   = 1'b0;
              resp0_d  = ACK;
              resp_n_d = 2'd1;
              p_st_d   = P_RESP;
            end
            default: begin
              resp0_d  = NAK;
              resp_n_d = 2'd1;
              p_st_d   = P_RESP;
            end
          endcase
        end
      end
      P_WHI, P_WLO: begin
        if (rx_valid) begin
          if (p_st_q == P_WHI) begin
            dwdata_d[15:8] = rx_sh_q;
            p_st_d         = P_WLO;
          end else begin
            dwdata_d[7:0] = rx_sh_q;
            p_st_d        = P_STROBE;
          end
        end else if (rx_ferr) begin
          p_st_d = P_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          resp0_d  = NAK;
          resp_n_d = 2'd1;
          p_st_d   = P_IDLE;
        end else begin
          tmo_d = tmo_q + 24'd1;
        end
      end
      P_STROBE: begin
        dw_c   = is_wr_q;
        dr_c   = !is_wr_q;
        p_st_d = P_RESP;
        if (is_wr_q) begin
          resp0_d  = ACK;
          resp_n_d = 2'd1;
        end else begin
          resp0_d  = dbg.drdata[15:8];
          resp1_d  = dbg.drdata[7:0];
          resp_n_d = 2'd2;
        end
      end
      P_RESP: begin
        if (resp_n_q == 2'd0 && qcnt_q == 2'd0) begin
          p_st_d = P_IDLE;
        end
      end
      default: p_st_d = P_IDLE;
    endcase
    // A breakpoint overrides any run command landing in the same cycle
    if (bp_hit) begin
      drun_d = 1'b0;
    end
  end

  // TX queue: pop for the transmitter first, then pending responses, then 'B'
  always_comb begin
    q0_d       = q0_q;
    q1_d       = q1_q;
    qcnt_d     = qcnt_q;
    resp_taken = 2'd0;
    bp_pend_d  = bp_hit;
    if (tx_pop) begin
      q0_d   = q1_q;
      qcnt_d = qcnt_q - 2'd1;
    end
    if (resp_n_q != 2'd0 && qcnt_d != 2'd2) begin
      if (qcnt_d == 2'd0) q0_d = resp0_q;
      else                q1_d = resp0_q;
      qcnt_d     = qcnt_d + 2'd1;
      resp_taken = 2'd1;
    end
    if (resp_n_q == 2'd2 && resp_taken == 2'd1 && qcnt_d != 2'd2) begin
      if (qcnt_d == 2'd0) q0_d = resp1_q;
      else                q1_d = resp1_q;
      qcnt_d     = qcnt_d + 2'd1;
      resp_taken = 2'd2;
    end
    if (bp_pend_q && resp_taken == resp_n_q && qcnt_d != 2'd2) begin
      if (qcnt_d == 2'd0) q0_d = BRK;
      else                q1_d = BRK;
      qcnt_d = qcnt_d + 2'd1;
    end
  end

  // Transmitter: next frame is loaded on the last stop-bit cycle, no idle gap
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_bit_d  = tx_bit_q;
    tx_cnt_d  = tx_cnt_q;
    tx_pop    = 1'b0;
    if (!tx_busy_q || (tx_cnt_q == 16'd0 && tx_bit_q == 4'd9)) begin
      if (qcnt_q != 2'd0) begin
        tx_pop    = 1'b1;
        tx_busy_d = 1'b1;
        tx_sh_d   = {1'b1, q0_q, 1'b0};
        tx_bit_d  = 4'd0;
        tx_cnt_d  = BIT_LAST;
      end else begin
        tx_busy_d = 1'b0;
      end
    end else if (tx_cnt_q != 16'd0) begin
      tx_cnt_d = tx_cnt_q - 16'd1;
    end else begin
      tx_sh_d  = {1'b1, tx_sh_q[9:1]};
      tx_bit_d = tx_bit_q + 4'd1;
      tx_cnt_d = BIT_LAST;
    end
    txd_d = tx_busy_d ? tx_sh_d[0] : 1'b1;
  end

  assign txd        = txd_q;
  assign drun       = drun_q;
  assign dbg.dr     = dr_c;
  assign dbg.dw     = dw_c;
  assign dbg.daddr  = addr_q;
  assign dbg.dwdata = dwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_b16_uart_debug.sv
`default_nettype none
// ============================================================================
// tb_b16_uart_debug : scoreboard bench for the UART debug bridge
// Rev 1.0
// ============================================================================
module tb_b16_uart_debug;

  localparam logic [15:0] DIV = 16'd8;
  localparam logic [7:0]  TMO = 8'd32;
  localparam int          DC  = int'(DIV);

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [15:0] d;
  } strb_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic rxd = 1'b1;
  logic txd;
  logic drun;
  logic bp_hit = 1'b0;
  logic mon_en = 1'b1;
  bit   drun_m = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_tx[$];
  strb_t      exp_strb[$];

  b16_uart_debug_if dbg();

  b16_uart_debug #(.DIV(DIV), .TIMEOUT(TMO)) dut (
    .clk    (clk),
    .nreset (nreset),
    .rxd    (rxd),
    .txd    (txd),
    .drun   (drun),
    .bp_hit (bp_hit),
    .dbg    (dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    tick(DC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(DC);
    end
    rxd = stop;
    tick(DC);
    rxd = 1'b1;
    if (!stop) tick(DC);
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_tx.size() != 0 || exp_strb.size() != 0) && t < 3000) begin
      tick(1);
      t++;
    end
    chk("pending_responses", exp_tx.size() + exp_strb.size(), 0);
    exp_tx.delete();
    exp_strb.delete();
    tick(2 * DC);
  endtask

  // Reference model at the command level: what a PC should see for one command
  task automatic issue(input logic [7:0] c, input logic [15:0] wd, input logic [15:0] rv);
    case (c[7:4])
      4'h1: begin
        if (drun_m) begin
          exp_tx.push_back(8'h15);
          send_byte(c, 1'b1);
        end else begin
          exp_strb.push_back('{1'b1, c[2:0], wd});
          exp_tx.push_back(8'h06);
          send_byte(c, 1'b1);
          send_byte(wd[15:8], 1'b1);
          send_byte(wd[7:0], 1'b1);
        end
      end
      4'h2: begin
        if (drun_m) begin
          exp_tx.push_back(8'h15);
        end else begin
          dbg.drdata = rv;
          exp_strb.push_back('{1'b0, c[2:0], 16'h0});
          exp_tx.push_back(rv[15:8]);
          exp_tx.push_back(rv[7:0]);
        end
        send_byte(c, 1'b1);
      end
      4'h3: begin
        drun_m = 1'b1;
        exp_tx.push_back(8'h06);
        send_byte(c, 1'b1);
      end
      4'h4: begin
        drun_m = 1'b0;
        exp_tx.push_back(8'h06);
        send_byte(c, 1'b1);
      end
      default: begin
        exp_tx.push_back(8'h15);
        send_byte(c, 1'b1);
      end
    endcase
    wait_done();
    chk("drun", drun, drun_m);
  endtask

  task automatic bp_pulse();
    @(negedge clk);
    bp_hit = 1'b1;
    @(negedge clk);
    bp_hit = 1'b0;
  endtask

  // TX monitor: decodes each frame from txd and scores it
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    logic       stp;
    forever begin
      @(negedge txd);
      if (!nreset) continue;
      repeat (DC / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        tick(DC);
        b[i] = txd;
      end
      tick(DC);
      stp = txd;
      if (mon_en) begin
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx_unexpected: got byte %02h, expected none", b);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_byte", b, e);
          chk("tx_stop", stp, 1);
        end
      end
    end
  end

  // Strobe monitor: every dr/dw cycle must match one expected strobe
  always @(negedge clk) begin
    strb_t s;
    if (nreset && (dbg.dr || dbg.dw)) begin
      chk("dr_dw_exclusive", dbg.dr & dbg.dw, 0);
      if (exp_strb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL strobe_unexpected: got dr=%0b dw=%0b daddr=%0d, expected none",
                 dbg.dr, dbg.dw, dbg.daddr);
      end else begin
        s = exp_strb.pop_front();
        chk("strobe_kind_dw", dbg.dw, s.wr);
        chk("strobe_daddr", dbg.daddr, s.a);
        if (s.wr) chk("strobe_dwdata", dbg.dwdata, s.d);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    int r;
    int o;
    dbg.drdata = 16'h0;
    tick(5);
    nreset = 1'b1;
    tick(1000);
    chk("reset_txd", txd, 1);
    chk("reset_drun", drun, 1);
    chk("reset_dr", dbg.dr, 0);
    chk("reset_dw", dbg.dw, 0);
    chk("reset_daddr", dbg.daddr, 0);
    chk("reset_dwdata", dbg.dwdata, 0);

    // halt, write, read
    issue(8'h40, 16'h0, 16'h0);
    issue(8'h15, 16'h1234, 16'h0);
    issue(8'h25, 16'h0, 16'hBEEF);

    // strobes refused while running; unknown op
    issue(8'h30, 16'h0, 16'h0);
    issue(8'h20, 16'h0, 16'h1111);
    issue(8'h70, 16'h0, 16'h0);

    // inter-byte timeout
    issue(8'h40, 16'h0, 16'h0);
    exp_tx.push_back(8'h15);
    send_byte(8'h13, 1'b1);
    send_byte(8'hAA, 1'b1);
    wait_done();
    issue(8'h40, 16'h0, 16'h0);

    // framing error mid-command, then a short glitch
    send_byte(8'h11, 1'b1);
    send_byte(8'h5A, 1'b0);
    tick(600);
    issue(8'h40, 16'h0, 16'h0);
    rxd = 1'b0;
    tick(2);
    rxd = 1'b1;
    tick(300);
    issue(8'h40, 16'h0, 16'h0);

    // randomized command mix
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 5);
      case (r)
        0: issue({4'h1, 1'($urandom), 3'($urandom)}, 16'($urandom), 16'h0);
        1: issue({4'h2, 1'($urandom), 3'($urandom)}, 16'h0, 16'($urandom));
        2: issue(8'h30, 16'h0, 16'h0);
        3: issue(8'h40, 16'h0, 16'h0);
        4: begin
          o = $urandom_range(5, 16);
          if (o == 16) o = 0;
          issue({4'(o), 4'($urandom)}, 16'h0, 16'h0);
        end
        default: begin
          exp_tx.push_back(8'h42);
          drun_m = 1'b0;
          bp_pulse();
          wait_done();
          chk("drun_after_bp", drun, drun_m);
        end
      endcase
    end

    // bp_hit in the same cycle as a completed run command
    issue(8'h40, 16'h0, 16'h0);
    exp_tx.push_back(8'h06);
    exp_tx.push_back(8'h42);
    drun_m = 1'b0;
    fork
      send_byte(8'h30, 1'b1);
      begin
        t = 0;
        while (dut.rx_valid !== 1'b1 && t < 400) begin
          @(negedge clk);
          t++;
        end
        chk("rx_valid_seen", dut.rx_valid, 1);
        bp_hit = 1'b1;
        @(negedge clk);
        bp_hit = 1'b0;
      end
    join
    wait_done();
    chk("drun_bp_wins", drun, 0);

    // reset in the middle of a TX frame
    send_byte(8'h70, 1'b1);
    t = 0;
    while (txd !== 1'b0 && t < 400) begin
      tick(1);
      t++;
    end
    chk("tx_frame_started", txd, 0);
    mon_en = 1'b0;
    tick(3 * DC);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    chk("midframe_reset_txd", txd, 1);
    chk("midframe_reset_drun", drun, 1);
    exp_tx.delete();
    exp_strb.delete();
    tick(3);
    nreset = 1'b1;
    drun_m = 1'b1;
    tick(200);
    mon_en = 1'b1;
    issue(8'h40, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
